// File: rtl/letc_core_mem_req_queue.sv
// In-order memory-stage queue between Execute and Memory 2.
// Issues DMSS requests in program order and releases each entry once its request is accepted.
module letc_core_mem_req_queue #(
    parameter  int PAYLOAD_W = 64,
    parameter  int ADDR_W    = 32,
    parameter  int DEPTH     = 2,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic                 in_mem_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [ADDR_W-1:0]    req_addr,
    output logic [CNT_W-1:0]     occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   WRAP = (PTR_W + 1)'(DEPTH);

    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [ADDR_W-1:0]    r_addr    [DEPTH];
    logic [DEPTH-1:0]     r_mem_req;
    logic [DEPTH-1:0]     r_sent;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_gate;
    logic                 w_enq;
    logic                 w_deq;
    logic                 w_req_fire;
    logic                 w_found;
    logic [PTR_W-1:0]     w_sel;
    logic [PTR_W:0]       w_sum [DEPTH];
    logic [PTR_W-1:0]     w_idx [DEPTH];

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // w_idx[i] is the i-th oldest slot; the wrap is explicit so odd DEPTH works.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_sum[i] = {1'b0, r_rd_ptr} + (PTR_W + 1)'(i);
            w_idx[i] = (w_sum[i] >= WRAP) ? PTR_W'(w_sum[i] - WRAP)
                                          : w_sum[i][PTR_W-1:0];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && (CNT_W'(i) < r_count) &&
                r_mem_req[w_idx[i]] && !r_sent[w_idx[i]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[i];
            end
        end
    end

    assign w_gate     = rst_n && !flush && !stall;
    assign in_ready   = w_gate && (r_count < FULL);
    assign req_valid  = w_gate && w_found;
    assign req_addr   = (rst_n && w_found) ? r_addr[w_sel] : '0;
    assign out_valid  = w_gate && (r_count != '0) &&
                        (!r_mem_req[r_rd_ptr] || r_sent[r_rd_ptr]);
    assign out_payload = r_payload[r_rd_ptr];
    assign out_addr    = r_addr[r_rd_ptr];
    assign occupancy   = r_count;

    assign w_enq      = in_valid && in_ready;
    assign w_deq      = out_valid && out_ready;
    assign w_req_fire = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_payload[r_wr_ptr] <= in_payload;
            r_addr[r_wr_ptr]    <= in_addr;
            r_mem_req[r_wr_ptr] <= in_mem_req;
        end
    end

    // Flush and reset share one path; stall freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sent   <= '0;
        end else if (!stall) begin
            if (w_req_fire) r_sent[w_sel] <= 1'b1;
            if (w_enq) begin
                r_sent[r_wr_ptr] <= 1'b0;
                r_wr_ptr         <= f_inc(r_wr_ptr);
            end
            if (w_deq) r_rd_ptr <= f_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

endmodule

// File: tb/tb_letc_core_mem_req_queue.sv
// Bench for letc_core_mem_req_queue at DEPTH 2, 3 and 4.
// Each instance is compared every cycle against an ordered-list model.
module tb_letc_core_mem_req_queue;

    localparam int N = 3;

    typedef struct packed {
        logic [63:0] pl;
        logic [31:0] ad;
        logic        mr;
        logic        sn;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush      [N];
    logic        stall      [N];
    logic        in_valid   [N];
    logic        in_ready   [N];
    logic [63:0] in_payload [N];
    logic [31:0] in_addr    [N];
    logic        in_mem_req [N];
    logic        out_valid  [N];
    logic        out_ready  [N];
    logic [63:0] out_payload[N];
    logic [31:0] out_addr   [N];
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic [31:0] req_addr   [N];
    logic [3:0]  occ        [N];

    ent_t mq [N][8];
    int   mc [N];
    bit   acc [N];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int D  = g + 2;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] w_occ;
        letc_core_mem_req_queue #(
            .PAYLOAD_W(64), .ADDR_W(32), .DEPTH(D)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .flush(flush[g]), .stall(stall[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_payload(in_payload[g]), .in_addr(in_addr[g]),
            .in_mem_req(in_mem_req[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_payload(out_payload[g]), .out_addr(out_addr[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_addr(req_addr[g]), .occupancy(w_occ)
        );
        assign occ[g] = 4'(w_occ);
    end

    task automatic chk(input string tag, input int k,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h",
                   tag, k, obs, exp);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < N; k++) begin
            in_valid[k]   = 1'b0;
            in_mem_req[k] = 1'b0;
            in_payload[k] = '0;
            in_addr[k]    = '0;
            out_ready[k]  = 1'b1;
            req_ready[k]  = 1'b1;
            flush[k]      = 1'b0;
            stall[k]      = 1'b0;
        end
    endtask

    // Check all outputs mid-cycle against the model, then advance it at the edge.
    task automatic cyc();
        #4;
        for (int k = 0; k < N; k++) begin
            int          sel;
            logic        g;
            logic        e_ir;
            logic        e_rv;
            logic        e_ov;
            logic [31:0] e_ra;
            sel = -1;
            g   = rst_n && !flush[k] && !stall[k];
            for (int i = 0; i < mc[k]; i++)
                if (sel < 0 && mq[k][i].mr && !mq[k][i].sn) sel = i;
            e_ir = g && (mc[k] < k + 2);
            e_rv = g && (sel >= 0);
            e_ra = (rst_n && sel >= 0) ? mq[k][sel].ad : 32'h0;
            e_ov = g && (mc[k] > 0) && (!mq[k][0].mr || mq[k][0].sn);
            chk("in_ready", k, 64'(in_ready[k]), 64'(e_ir));
            chk("req_valid", k, 64'(req_valid[k]), 64'(e_rv));
            chk("req_addr", k, 64'(req_addr[k]), 64'(e_ra));
            chk("out_valid", k, 64'(out_valid[k]), 64'(e_ov));
            chk("occupancy", k, 64'(occ[k]), 64'(mc[k]));
            if (mc[k] > 0) begin
                chk("out_payload", k, out_payload[k], mq[k][0].pl);
                chk("out_addr", k, 64'(out_addr[k]), 64'(mq[k][0].ad));
            end
            acc[k] = e_ir && in_valid[k];
            if (!rst_n || flush[k]) begin
                mc[k] = 0;
            end else if (!stall[k]) begin
                if (e_rv && req_ready[k]) mq[k][sel].sn = 1'b1;
                if (e_ov && out_ready[k]) begin
                    for (int i = 0; i < mc[k] - 1; i++) mq[k][i] = mq[k][i+1];
                    mc[k]--;
                end
                if (acc[k]) begin
                    mq[k][mc[k]] = '{in_payload[k], in_addr[k], in_mem_req[k], 1'b0};
                    mc[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) cyc();
    endtask

    initial begin
        int n;
        for (int k = 0; k < N; k++) mc[k] = 0;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // reset held for three cycles, then released
        repeat (3) cyc();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < N; k++) chk("rel_in_ready", k, 64'(in_ready[k]), 64'd1);
        cyc();

        // DEPTH=2 non-mem streaming
        for (int i = 0; i < 8; i++) begin
            in_valid[0]   = 1'b1;
            in_payload[0] = 64'(i);
            in_addr[0]    = 32'(i * 4);
            if (i > 0) begin
                #1;
                chk("stream_valid", 0, 64'(out_valid[0]), 64'd1);
                chk("stream_pl", 0, out_payload[0], 64'(i - 1));
            end
            cyc();
        end
        in_valid[0] = 1'b0;
        #1;
        chk("stream_last", 0, out_payload[0], 64'd7);
        cyc();
        drain(2);

        // DEPTH=2 load under DMSS backpressure
        req_ready[0]  = 1'b0;
        in_valid[0]   = 1'b1;
        in_mem_req[0] = 1'b1;
        in_addr[0]    = 32'h1000;
        in_payload[0] = 64'h55;
        cyc();
        in_mem_req[0] = 1'b0;
        in_addr[0]    = 32'h2000;
        in_payload[0] = 64'hA;
        cyc();
        in_valid[0] = 1'b0;
        repeat (4) begin
            #1;
            chk("bp_req_valid", 0, 64'(req_valid[0]), 64'd1);
            chk("bp_req_addr", 0, 64'(req_addr[0]), 64'h1000);
            chk("bp_out_valid", 0, 64'(out_valid[0]), 64'd0);
            chk("bp_occ", 0, 64'(occ[0]), 64'd2);
            chk("bp_in_ready", 0, 64'(in_ready[0]), 64'd0);
            cyc();
        end
        req_ready[0] = 1'b1;
        cyc();
        #1;
        chk("bp_load_out", 0, out_payload[0], 64'h55);
        chk("bp_load_valid", 0, 64'(out_valid[0]), 64'd1);
        cyc();
        #1;
        chk("bp_nonmem_out", 0, out_payload[0], 64'hA);
        chk("bp_nonmem_valid", 0, 64'(out_valid[0]), 64'd1);
        cyc();
        drain(2);

        // DEPTH=4 in-order request lookahead with out_ready low
        out_ready[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[2]   = (i < 3);
            in_mem_req[2] = 1'b1;
            in_addr[2]    = 32'((i + 1) * 16);
            in_payload[2] = 64'(100 + i);
            if (i > 0) begin
                #1;
                chk("la_req_valid", 2, 64'(req_valid[2]), 64'd1);
                chk("la_req_addr", 2, 64'(req_addr[2]), 64'(i * 16));
            end
            cyc();
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("la_out_valid", 2, 64'(out_valid[2]), 64'd1);
            chk("la_out_pl", 2, out_payload[2], 64'(100 + i));
            cyc();
        end
        drain(2);

        // DEPTH=3 flush with a pending request
        out_ready[1]  = 1'b0;
        in_valid[1]   = 1'b1;
        in_mem_req[1] = 1'b1;
        in_addr[1]    = 32'h40;
        in_payload[1] = 64'd1;
        cyc();
        in_addr[1]    = 32'h50;
        in_payload[1] = 64'd2;
        cyc();
        req_ready[1]  = 1'b0;
        in_mem_req[1] = 1'b0;
        in_addr[1]    = 32'h60;
        in_payload[1] = 64'd3;
        cyc();
        in_valid[1] = 1'b0;
        #1;
        chk("fl_occ_before", 1, 64'(occ[1]), 64'd3);
        chk("fl_pending", 1, 64'(req_addr[1]), 64'h50);
        flush[1] = 1'b1;
        #1;
        chk("fl_req_valid", 1, 64'(req_valid[1]), 64'd0);
        chk("fl_out_valid", 1, 64'(out_valid[1]), 64'd0);
        cyc();
        flush[1] = 1'b0;
        #1;
        chk("fl_occ_after", 1, 64'(occ[1]), 64'd0);
        cyc();

        // DEPTH=3 stall held two cycles
        req_ready[1]  = 1'b0;
        in_valid[1]   = 1'b1;
        in_mem_req[1] = 1'b1;
        in_addr[1]    = 32'h70;
        in_payload[1] = 64'd7;
        cyc();
        in_mem_req[1] = 1'b0;
        in_payload[1] = 64'd8;
        cyc();
        stall[1]     = 1'b1;
        out_ready[1] = 1'b1;
        req_ready[1] = 1'b1;
        repeat (2) begin
            #1;
            chk("st_in_ready", 1, 64'(in_ready[1]), 64'd0);
            chk("st_out_valid", 1, 64'(out_valid[1]), 64'd0);
            chk("st_req_valid", 1, 64'(req_valid[1]), 64'd0);
            chk("st_occ", 1, 64'(occ[1]), 64'd2);
            cyc();
        end
        drain(6);

        // DEPTH=3 wrap and full with out_ready toggling
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            in_valid[1]   = 1'b1;
            in_payload[1] = 64'(200 + n);
            if (c == 0 || acc[1]) begin
                in_mem_req[1] = 1'($urandom_range(0, 1));
                in_addr[1]    = $urandom;
            end
            out_ready[1] = (c % 2 == 0);
            cyc();
            if (acc[1]) n++;
        end
        if (n < 10) begin
            checks++;
            errors++;
            $error("FAIL wrap_budget accepted=%0d required=10", n);
        end
        drain(8);

        // randomized traffic on all instances, with one reset pulse
        for (int c = 0; c < 400; c++) begin
            rst_n = (c != 200);
            for (int k = 0; k < N; k++) begin
                in_valid[k]   = ($urandom_range(0, 3) != 0);
                in_mem_req[k] = 1'($urandom_range(0, 1));
                in_payload[k] = {$urandom, $urandom};
                in_addr[k]    = $urandom;
                out_ready[k]  = ($urandom_range(0, 3) != 0);
                req_ready[k]  = ($urandom_range(0, 2) != 0);
                flush[k]      = ($urandom_range(0, 39) == 0);
                stall[k]      = ($urandom_range(0, 11) == 0);
            end
            cyc();
        end
        rst_n = 1'b1;
        drain(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
